// File: rtl/alu_io_pkg.sv
// Shared types and constants for the ALU operand loader.
package alu_io_pkg;

   typedef enum logic [1:0] {
      S_A  = 2'd0,
      S_B  = 2'd1,
      S_OP = 2'd2,
      S_V  = 2'd3
   } loader_state_t;

   // Short debounce window so simulation stays fast.
   localparam int unsigned DEB_CYCLES_SIM = 4;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and rising-edge pulse.
module btn_debounce #(
   parameter int unsigned DEB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise_p
);

   localparam int unsigned CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          level_q;
   logic          rise_q;

   // The counter restarts whenever the synchronized input agrees with the level again.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw};
         rise_q <= 1'b0;
         if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
               level_q <= sync_q[1];
               rise_q  <= sync_q[1];
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign level  = level_q;
   assign rise_p = rise_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Sequentially loads A, B and opcode from switches and holds them for the ALU until acked.
module alu_operand_loader
   import alu_io_pkg::*;
#(
   parameter int unsigned N          = 4,
   parameter int unsigned OPW        = 4,
   parameter int unsigned DEB_CYCLES = 50000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   sw,
   input  logic [OPW-1:0] op_sw,
   input  logic           btn_load,
   input  logic           btn_clear,
   output logic [N-1:0]   a_out,
   output logic [N-1:0]   b_out,
   output logic [OPW-1:0] op_out,
   output logic           operands_valid,
   input  logic           consumer_ack,
   output logic [1:0]     stage
);

   logic [N-1:0]   sw_s1, sw_sync;
   logic [OPW-1:0] op_s1, op_sw_sync;
   logic           ld_p, clr_p;
   logic           load_level, clear_level;
   logic           unused_levels;

   loader_state_t  state;
   logic [N-1:0]   a_q, b_q;
   logic [OPW-1:0] op_q;
   logic           valid_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_s1      <= '0;
         sw_sync    <= '0;
         op_s1      <= '0;
         op_sw_sync <= '0;
      end else begin
         sw_s1      <= sw;
         sw_sync    <= sw_s1;
         op_s1      <= op_sw;
         op_sw_sync <= op_s1;
      end
   end

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_load_deb (
      .clk    (clk),
      .rst    (rst),
      .raw    (btn_load),
      .level  (load_level),
      .rise_p (ld_p)
   );

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_clear_deb (
      .clk    (clk),
      .rst    (rst),
      .raw    (btn_clear),
      .level  (clear_level),
      .rise_p (clr_p)
   );

   // Only the edge pulses drive the FSM; the held levels are not needed here.
   assign unused_levels = load_level ^ clear_level;

   // Clear outranks both load and ack; the bundle is frozen while in S_V.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
      end else if (clr_p) begin
         state   <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         unique case (state)
            S_A: begin
               if (ld_p) begin
                  a_q   <= sw_sync;
                  state <= S_B;
               end
            end
            S_B: begin
               if (ld_p) begin
                  b_q   <= sw_sync;
                  state <= S_OP;
               end
            end
            S_OP: begin
               if (ld_p) begin
                  op_q    <= op_sw_sync;
                  valid_q <= 1'b1;
                  state   <= S_V;
               end
            end
            S_V: begin
               if (consumer_ack) begin
                  valid_q <= 1'b0;
                  state   <= S_A;
               end
            end
            default: state <= S_A;
         endcase
      end
   end

   assign a_out          = a_q;
   assign b_out          = b_q;
   assign op_out         = op_q;
   assign operands_valid = valid_q;
   assign stage          = state;

endmodule
